// File: rtl/rv32i_fetch_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory, the execute-stage
// redirect path and decode.
interface rv32i_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        misalign_err;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, misalign_err,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, misalign_err,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
    output inst_ready
  );
endinterface

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch: issues word fetches, queues in-order responses in a
// 2-entry registered queue and handles redirects, dropping stale responses.
module rv32i_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2  // queue logic below is written for exactly 2 entries
) (
  input  logic               clock,
  input  logic               reset_n,
  rv32i_fetch_unit_if.master bus
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state, state_nx;
  logic [31:0] fetch_pc, fetch_pc_nx;
  logic [31:0] q_data [2];
  logic [31:0] q_pc   [2];
  logic        head, head_nx;
  logic [1:0]  count, count_nx;
  logic [1:0]  outstanding, outstanding_nx;
  logic [3:0]  drop_cnt, drop_nx;
  logic        misalign, misalign_nx;

  logic        req_fire, pop, rsp_drop, rsp_live, wr_en, wr_idx;
  logic [2:0]  in_flight;
  logic [31:0] rsp_pc;

  assign in_flight = {1'b0, outstanding} + {1'b0, count};
  assign req_fire  = bus.imem_req_valid & bus.imem_req_ready;
  assign pop       = bus.inst_valid & bus.inst_ready;
  assign rsp_drop  = bus.imem_rsp_valid & (drop_cnt != 4'd0);
  // A response with nothing outstanding and nothing to drop is ignored outright.
  assign rsp_live  = bus.imem_rsp_valid & (drop_cnt == 4'd0) & (outstanding != 2'd0);
  assign wr_en     = rsp_live & ~bus.redirect_valid;
  assign wr_idx    = head ^ count[0];
  // Live requests since the last redirect are sequential, so the oldest one's
  // address is recovered from fetch_pc instead of being stored per request.
  assign rsp_pc    = fetch_pc - {28'd0, outstanding, 2'b00};

  assign bus.imem_req_valid = reset_n && (state == RUN) && (in_flight < 3'(QDEPTH));
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.inst_valid     = (count != 2'd0);
  assign bus.inst_data      = q_data[head];
  assign bus.inst_pc        = q_pc[head];
  assign bus.misalign_err   = misalign;

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path can infer a latch.
    state_nx       = state;
    fetch_pc_nx    = fetch_pc;
    head_nx        = head;
    count_nx       = count;
    outstanding_nx = outstanding;
    drop_nx        = drop_cnt - 4'(rsp_drop);
    misalign_nx    = misalign;

    if (bus.redirect_valid) begin
      // Everything in flight, including a request handshaking now, becomes stale.
      drop_nx        = drop_cnt - 4'(rsp_drop) + 4'(outstanding) - 4'(rsp_live) + 4'(req_fire);
      outstanding_nx = 2'd0;
      count_nx       = 2'd0;
      head_nx        = 1'b0;
      fetch_pc_nx    = bus.redirect_pc;
      if (bus.redirect_pc[1:0] == 2'b00) begin
        state_nx    = RUN;
        misalign_nx = 1'b0;
      end else begin
        state_nx    = HALT;
        misalign_nx = 1'b1;
      end
    end else begin
      outstanding_nx = outstanding + 2'(req_fire) - 2'(rsp_live);
      count_nx       = count + 2'(rsp_live) - 2'(pop);
      head_nx        = head ^ pop;
      if (req_fire) fetch_pc_nx = fetch_pc + 32'd4;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      head        <= 1'b0;
      count       <= 2'd0;
      outstanding <= 2'd0;
      drop_cnt    <= 4'd0;
      misalign    <= 1'b0;
    end else begin
      state       <= state_nx;
      fetch_pc    <= fetch_pc_nx;
      head        <= head_nx;
      count       <= count_nx;
      outstanding <= outstanding_nx;
      drop_cnt    <= drop_nx;
      misalign    <= misalign_nx;
    end
  end

  // NOTE: the queue storage is reset because inst_data/inst_pc must read zero
  // out of reset; larger memories would normally be left unreset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        q_data[i] <= 32'd0;
        q_pc[i]   <= 32'd0;
      end
    end else if (wr_en) begin
      q_data[wr_idx] <= bus.imem_rsp_data;
      q_pc[wr_idx]   <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed bench for rv32i_fetch_unit with an in-order fixed-latency memory model.
module tb_rv32i_fetch_unit;

  logic clock = 1'b0;
  logic reset_n;
  rv32i_fetch_unit_if bus ();

  rv32i_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  // Memory model: fixed latency, in order, at most one response per cycle.
  int          lat = 1;
  int          cyc = 0;
  bit          spur = 1'b0;
  int          pend_due  [$];
  logic [31:0] pend_addr [$];
  logic [31:0] req_log   [$];

  always @(posedge clock) begin
    if (reset_n && bus.imem_req_valid && bus.imem_req_ready) begin
      pend_due.push_back(cyc + lat);
      pend_addr.push_back(bus.imem_req_addr);
      req_log.push_back(bus.imem_req_addr);
    end
    cyc++;
    #1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'd0;
    if (spur) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
    end else if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(pend_addr[0]);
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
    end
  end

  logic [31:0] got_pc   [$];
  logic [31:0] got_data [$];
  int          got_idx  [$];

  // Records delivered instructions, starting from the next falling edge.
  task automatic collect(input int n, input int budget);
    got_pc.delete();
    got_data.delete();
    got_idx.delete();
    for (int i = 0; i < budget && got_pc.size() < n; i++) begin
      @(negedge clock);
      if (bus.inst_valid && bus.inst_ready) begin
        got_pc.push_back(bus.inst_pc);
        got_data.push_back(bus.inst_data);
        got_idx.push_back(i);
      end
    end
    check("collect_count", 32'(got_pc.size()), 32'(n));
    while (got_pc.size() < n) begin
      got_pc.push_back('x);
      got_data.push_back('x);
      got_idx.push_back(-1);
    end
  endtask

  task automatic expect_seq(input string tag, input logic [31:0] pc0, input int n);
    logic [31:0] pc;
    pc = pc0;
    for (int k = 0; k < n; k++) begin
      check({tag, "_pc"},   got_pc[k],   pc);
      check({tag, "_data"}, got_data[k], mem_word(pc));
      pc = pc + 32'd4;
    end
  endtask

  task automatic enter_reset(input int l, input logic rdy);
    reset_n            = 1'b0;
    lat                = l;
    spur               = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = rdy;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    pend_due.delete();
    pend_addr.delete();
    req_log.delete();
    repeat (3) @(negedge clock);
  endtask

  // Leaves the caller just after the rising edge that starts cycle 0.
  task automatic leave_reset();
    @(posedge clock);
    #1 reset_n = 1'b0 | 1'b1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    @(posedge clock);
    #1 bus.redirect_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int mark;
    reset_n            = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'd0;

    // Reset state, then sequential fetch with 1-cycle memory.
    enter_reset(1, 1'b1);
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_inst_data", bus.inst_data, 32'd0);
    check("rst_inst_pc", bus.inst_pc, 32'd0);
    check("rst_misalign", 32'(bus.misalign_err), 32'd0);
    leave_reset();
    @(negedge clock);
    check("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("first_req_addr", bus.imem_req_addr, 32'h0000_0000);
    // That falling edge was cycle 0; collect restarts its index at cycle 1.
    collect(6, 60);
    check("first_inst_cycle", 32'(got_idx[0]), 32'd1);
    expect_seq("seq", 32'h0, 6);
    for (int k = 0; k < 3; k++) check("req_addr_log", req_log[k], 32'(4 * k));

    // Decode stalled: queue fills, issue stops, then a spurious response is ignored.
    enter_reset(1, 1'b0);
    leave_reset();
    repeat (10) @(negedge clock);
    check("stall_req_count", 32'(req_log.size()), 32'd2);
    check("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("stall_inst_valid", 32'(bus.inst_valid), 32'd1);
    check("stall_head_pc", bus.inst_pc, 32'h0);
    spur = 1'b1;
    @(posedge clock);
    #2 spur = 1'b0;
    @(negedge clock);
    check("spur_head_pc", bus.inst_pc, 32'h0);
    check("spur_head_data", bus.inst_data, mem_word(32'h0));
    @(posedge clock);
    #1 bus.inst_ready = 1'b1;
    collect(3, 40);
    expect_seq("release", 32'h0, 3);

    // Two requests in flight with 3-cycle memory, then redirect drops both.
    enter_reset(3, 1'b1);
    leave_reset();
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    check("lat3_req_count", 32'(req_log.size()), 32'd2);
    check("lat3_req_valid", 32'(bus.imem_req_valid), 32'd0);
    redirect(32'h0000_0100);
    collect(2, 40);
    expect_seq("redir", 32'h100, 2);
    check("redir_req_addr", req_log[2], 32'h100);

    // Misaligned target halts fetch; aligned target resumes it.
    redirect(32'h0000_0102);
    repeat (6) @(negedge clock);
    check("halt_misalign", 32'(bus.misalign_err), 32'd1);
    check("halt_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("halt_inst_valid", 32'(bus.inst_valid), 32'd0);
    mark = req_log.size();
    repeat (5) @(negedge clock);
    check("halt_no_req", 32'(req_log.size()), 32'(mark));
    redirect(32'h0000_0306);
    @(negedge clock);
    check("halt2_misalign", 32'(bus.misalign_err), 32'd1);
    check("halt2_req_valid", 32'(bus.imem_req_valid), 32'd0);
    redirect(32'h0000_0200);
    collect(1, 40);
    expect_seq("resume", 32'h200, 1);
    check("resume_misalign", 32'(bus.misalign_err), 32'd0);

    // Address wrap at the top of the address space; the request to 0 in flight is dropped.
    enter_reset(1, 1'b1);
    leave_reset();
    redirect(32'hFFFF_FFFC);
    collect(3, 40);
    expect_seq("wrap", 32'hFFFF_FFFC, 3);
    check("wrap_log0", req_log[0], 32'h0);
    check("wrap_log1", req_log[1], 32'hFFFF_FFFC);
    check("wrap_log2", req_log[2], 32'h0);

    // Redirect coincident with a pop of a full queue.
    enter_reset(1, 1'b0);
    leave_reset();
    repeat (6) @(negedge clock);
    check("full_inst_valid", 32'(bus.inst_valid), 32'd1);
    check("full_head_pc", bus.inst_pc, 32'h0);
    bus.inst_ready = 1'b1;
    redirect(32'h0000_0400);
    @(negedge clock);
    check("flush_inst_valid", 32'(bus.inst_valid), 32'd0);
    collect(2, 40);
    expect_seq("after_flush", 32'h400, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
